simple_risc_cpu: RTL and testbench

Multi-cycle 16-bit Simple RISC Machine core. It fetches one instruction at a time from external memory through a 9-bit program counter, decodes it, and executes it on an internal 8×16-bit register file, 1-bit shifter and ALU. It exposes the datapath result register and the N/V/Z status flags. It sits between the instruction memory and the system I/O as the top-level processing element.

---
 rtl/simple_risc_cpu.sv | 124 ++++++++++++
 tb/tb_simple_risc_cpu.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/simple_risc_cpu.sv
// Multi-cycle 16-bit Simple RISC Machine core: fetch via 9-bit PC, 8x16 register file, shifter, ALU, N/V/Z flags.
// Optional feature macro CPU_HALT_EN: opcode 111 parks the core in HALT until reset.
module simple_risc_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] read_data,
  output logic [1:0]  mem_cmd,
  output logic [8:0]  mem_addr,
  output logic [15:0] out,
  output logic        N,
  output logic        V,
  output logic        Z
);
  typedef enum logic [3:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_GETA, S_GETB, S_ALU, S_WR, S_WIMM, S_HALT
  } state_t;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_READ = 2'b01;

  state_t      state, state_nxt;
  logic [8:0]  pc;
  logic [15:0] ir, a, b;
  logic [15:0] rf [8];

  logic [2:0]  opcode;
  logic [1:0]  op;
  logic        is_cmp;
  logic [15:0] shb, diff, alu_res;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign is_cmp = (opcode == 3'b101) && (op == 2'b01);

  // Shifter only ever sees the Rm operand.
  always_comb begin
    shb = b;
    case (ir[4:3])
      2'b01:   shb = {b[14:0], 1'b0};
      2'b10:   shb = {1'b0, b[15:1]};
      2'b11:   shb = {b[15], b[15:1]};
      default: shb = b;
    endcase
    diff    = a - shb;
    alu_res = shb;
    if (opcode == 3'b101) begin
      case (op)
        2'b00:   alu_res = a + shb;
        2'b10:   alu_res = a & shb;
        2'b11:   alu_res = ~shb;
        default: alu_res = diff;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:  state_nxt = S_IF1;
      S_IF1:  state_nxt = S_IF2;
      S_IF2:  state_nxt = S_UPC;
      S_UPC:  state_nxt = S_DEC;
      S_DEC: begin
        state_nxt = S_IF1;
        if (opcode == 3'b110 && op == 2'b10)      state_nxt = S_WIMM;
        else if (opcode == 3'b110 && op == 2'b00) state_nxt = S_GETB;
        else if (opcode == 3'b101 && op == 2'b11) state_nxt = S_GETB;
        else if (opcode == 3'b101)                state_nxt = S_GETA;
`ifdef CPU_HALT_EN
        else if (opcode == 3'b111)                state_nxt = S_HALT;
`endif
      end
      S_GETA: state_nxt = S_GETB;
      S_GETB: state_nxt = S_ALU;
      S_ALU:  state_nxt = is_cmp ? S_IF1 : S_WR;
      S_WR:   state_nxt = S_IF1;
      S_WIMM: state_nxt = S_IF1;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RST;
    else        state <= state_nxt;
  end

  // Sources are latched into a/b before WR, so Rd==Rm reads the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= '0;
      ir  <= '0;
      a   <= '0;
      b   <= '0;
      out <= '0;
      N   <= 1'b0;
      V   <= 1'b0;
      Z   <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IF2:  ir <= read_data;
        S_UPC:  pc <= pc + 9'd1;
        S_GETA: a  <= rf[ir[10:8]];
        S_GETB: b  <= rf[ir[2:0]];
        S_ALU: begin
          if (is_cmp) begin
            N <= diff[15];
            Z <= (diff == 16'd0);
            V <= (a[15] != shb[15]) && (diff[15] != a[15]);
          end else begin
            out <= alu_res;
          end
        end
        S_WR:   rf[ir[7:5]]  <= out;
        S_WIMM: rf[ir[10:8]] <= {{8{ir[7]}}, ir[7:0]};
        default: ;
      endcase
    end
  end

  assign mem_addr = pc;
  assign mem_cmd  = (state == S_IF1 || state == S_IF2) ? CMD_READ : CMD_NONE;
endmodule

// File: tb/tb_simple_risc_cpu.sv
// Directed bench for simple_risc_cpu: program in a memory model, expected per-instruction results in a queue.
module tb_simple_risc_cpu;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] read_data;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] out;
  logic        N, V, Z;

  logic [15:0] mem [512];
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [8:0]  addr;
    int          cyc;
    logic [15:0] res;
    logic [2:0]  nvz;
  } exp_t;
  exp_t sb[$];

  simple_risc_cpu dut (
    .clk(clk), .reset(reset), .read_data(read_data), .mem_cmd(mem_cmd),
    .mem_addr(mem_addr), .out(out), .N(N), .V(V), .Z(Z)
  );

  assign read_data = mem[mem_addr];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      $error("%s", tag);
    end
  endtask

  task automatic load(input int addr, input logic [15:0] instr, input int cyc,
                      input logic [15:0] res, input logic [2:0] nvz);
    exp_t e;
    mem[addr] = instr;
    e.addr = addr[8:0]; e.cyc = cyc; e.res = res; e.nvz = nvz;
    sb.push_back(e);
  endtask

  // Entered #1 after the edge into IF1; leaves #1 after the edge into the next IF1.
  task automatic run_next();
    exp_t e;
    int   n;
    bit   seen;
    e = sb.pop_front();
    chk("fetch_addr", mem_addr, e.addr);
    n = 0; seen = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (mem_cmd == 2'b00) seen = 1;
    end while (!(seen && mem_cmd == 2'b01) && n < 30);
    chk("cycles", n, e.cyc);
    chk("out", out, e.res);
    chk("nvz", {N, V, Z}, e.nvz);
  endtask

  initial begin
    int pos;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;

    load( 0, 16'hD007, 5, 16'h0000, 3'b000); // MOV R0,#7
    load( 1, 16'hD102, 5, 16'h0000, 3'b000); // MOV R1,#2
    load( 2, 16'hA041, 8, 16'h0009, 3'b000); // ADD R2,R0,R1
    load( 3, 16'hC062, 7, 16'h0009, 3'b000); // MOV R3,R2
    load( 4, 16'hD7FF, 5, 16'h0009, 3'b000); // MOV R7,#-1
    load( 5, 16'hC087, 7, 16'hFFFF, 3'b000); // MOV R4,R7
    load( 6, 16'hD103, 5, 16'hFFFF, 3'b000); // MOV R1,#3
    load( 7, 16'hD303, 5, 16'hFFFF, 3'b000); // MOV R3,#3
    load( 8, 16'hA903, 7, 16'hFFFF, 3'b001); // CMP R1,R3
    load( 9, 16'hD606, 5, 16'hFFFF, 3'b001); // MOV R6,#6
    load(10, 16'hAE03, 7, 16'hFFFF, 3'b000); // CMP R6,R3
    load(11, 16'hAE0B, 7, 16'hFFFF, 3'b001); // CMP R6,R3,LSL#1
    load(12, 16'hA906, 7, 16'hFFFF, 3'b100); // CMP R1,R6 -> negative
    load(13, 16'hC0B7, 7, 16'h7FFF, 3'b100); // MOV R5,R7,LSR#1
    load(14, 16'hAD07, 7, 16'h7FFF, 3'b110); // CMP R5,R7 -> overflow
    load(15, 16'hD000, 5, 16'h7FFF, 3'b110); // MOV R0,#0
    load(16, 16'hB840, 7, 16'hFFFF, 3'b110); // MVN R2,R0
    load(17, 16'hC083, 7, 16'h0003, 3'b110); // MOV R4,R3
    load(18, 16'hB747, 8, 16'hFFFF, 3'b110); // AND R2,R7,R7
    load(19, 16'hB8B3, 7, 16'hFFFE, 3'b110); // MVN R5,R3,LSR#1
    load(20, 16'hB8A5, 7, 16'h0001, 3'b110); // MVN R5,R5
    load(21, 16'hC09F, 7, 16'hFFFF, 3'b110); // MOV R4,R7,ASR#1
    load(22, 16'h0000, 4, 16'hFFFF, 3'b110); // NOP
    pos = 23;
`ifndef CPU_HALT_EN
    load(23, 16'hE000, 4, 16'hFFFF, 3'b110); // 111 is a NOP without halt
    pos = 24;
`endif
    for (int i = pos; i < 512; i++) load(i, 16'h0000, 4, 16'hFFFF, 3'b110);

    // Reset held low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_cmd", mem_cmd, 2'b00);
    chk("rst_mem_addr", mem_addr, 9'd0);
    chk("rst_out", out, 16'h0000);
    chk("rst_nvz", {N, V, Z}, 3'b000);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("first_fetch_cmd", mem_cmd, 2'b01);

    // Program plus NOP run to the top of memory
    while (sb.size() > 0) run_next();
    chk("wrap_addr", mem_addr, 9'd0);
    chk("wrap_cmd", mem_cmd, 2'b01);

    // Re-run from 0, then reset inside the ADD's ALU state
    sb.push_back('{addr: 9'd0, cyc: 5, res: 16'hFFFF, nvz: 3'b110});
    sb.push_back('{addr: 9'd1, cyc: 5, res: 16'hFFFF, nvz: 3'b110});
    while (sb.size() > 0) run_next();
    chk("add_addr", mem_addr, 9'd2);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_out", out, 16'hFFFF);
    reset = 1'b0;
    #1;
    chk("mid_rst_out", out, 16'h0000);
    chk("mid_rst_nvz", {N, V, Z}, 3'b000);
    chk("mid_rst_cmd", mem_cmd, 2'b00);
    chk("mid_rst_addr", mem_addr, 9'd0);
    mem[0] = 16'hC062; // MOV R3,R2 exposes R2 after reset
    sb.push_back('{addr: 9'd0, cyc: 7, res: 16'h0000, nvz: 3'b000});
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rerst_fetch_cmd", mem_cmd, 2'b01);
    while (sb.size() > 0) run_next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
